// File: rtl/mdu_seq.sv
// mdu_seq: sequencer that issues one multiply/divide to an external MDU, waits a fixed latency and returns the result with XER/CR0 status.
//   Parameters: MUL_LAT and DIV_LAT set the accept-to-result latency (1..63) for each op class.
//     ARCH_WIDTH and MDUOp_WIDTH set the operand and opcode widths.
//   Ports:
//     clk, rst_n (async, active-low)   clock and reset
//     flush                            abort any operation in flight
//     start, op, srcA, srcB, oe, rc    issue request
//     busy                             high from accept until the result is consumed
//     mdu_A, mdu_B, mdu_Op, mdu_C, mdu_D   MDU operands/op out, result and flags in
//     res_valid, res_ready             result handshake
//     res_data, res_ov, res_so, res_cr0    result value and status
//     res_xer_we, res_cr0_we           XER and CR0 write enables
//   Bit 0 is the MSB on every vector.
//   Optional feature: define MDU_DIV0_EARLY_EN to finish divides by zero without waiting DIV_LAT.
module mdu_seq #(
  parameter int MUL_LAT     = 4,
  parameter int DIV_LAT     = 34,
  parameter int ARCH_WIDTH  = 32,
  parameter int MDUOp_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    start,
  input  logic [0:MDUOp_WIDTH-1]  op,
  input  logic [0:ARCH_WIDTH-1]   srcA,
  input  logic [0:ARCH_WIDTH-1]   srcB,
  input  logic                    oe,
  input  logic                    rc,
  output logic                    busy,
  output logic [0:ARCH_WIDTH-1]   mdu_A,
  output logic [0:ARCH_WIDTH-1]   mdu_B,
  output logic [0:MDUOp_WIDTH-1]  mdu_Op,
  input  logic [0:ARCH_WIDTH-1]   mdu_C,
  input  logic [0:3]              mdu_D,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [0:ARCH_WIDTH-1]   res_data,
  output logic                    res_ov,
  output logic                    res_so,
  output logic [0:3]              res_cr0,
  output logic                    res_xer_we,
  output logic                    res_cr0_we
);
  localparam logic [0:MDUOp_WIDTH-1] OP_MULH  = MDUOp_WIDTH'(1);
  localparam logic [0:MDUOp_WIDTH-1] OP_MULHU = MDUOp_WIDTH'(2);
  localparam logic [0:MDUOp_WIDTH-1] OP_MULW  = MDUOp_WIDTH'(3);
  localparam logic [0:MDUOp_WIDTH-1] OP_DIVW  = MDUOp_WIDTH'(4);
  localparam logic [0:MDUOp_WIDTH-1] OP_DIVWU = MDUOp_WIDTH'(5);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic [5:0] cnt;
  logic [0:MDUOp_WIDTH-1] op_q;
  logic [0:ARCH_WIDTH-1] a_q, b_q;
  logic oe_q, rc_q, so, cr_lt, cr_gt, cr_eq;
  logic is_mul, is_div, accept, capture, div0;
  // Only the OV flag of mdu_D is consumed; CR0 is rebuilt from the captured value.
  logic unused_d;
  assign unused_d = ^mdu_D[1:3];
  always_comb begin
    is_mul = op == OP_MULH || op == OP_MULHU || op == OP_MULW;
    is_div = op == OP_DIVW || op == OP_DIVWU;
    accept = state == IDLE && start && (is_mul || is_div) && !flush;
    capture = state == EXEC && cnt == 6'd0 && !flush;
`ifdef MDU_DIV0_EARLY_EN
    div0 = is_div && srcB == '0;
`else
    div0 = 1'b0;
`endif
    state_nx = flush ? IDLE :
               accept ? (div0 ? DONE : EXEC) :
               capture ? DONE :
               (state == DONE && res_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      oe_q <= 1'b0;
      rc_q <= 1'b0;
      res_data <= '0;
      res_ov <= 1'b0;
      so <= 1'b0;
      cr_lt <= 1'b0;
      cr_gt <= 1'b0;
      cr_eq <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      op_q <= op;
      a_q <= srcA;
      b_q <= srcB;
      oe_q <= oe;
      rc_q <= rc;
      cnt <= is_div ? 6'(DIV_LAT - 1) : 6'(MUL_LAT - 1);
      if (div0) begin
        res_data <= '0;
        res_ov <= 1'b1;
        cr_lt <= 1'b0;
        cr_gt <= 1'b0;
        cr_eq <= 1'b1;
        if (oe) so <= 1'b1;
      end
    end else if (capture) begin
      res_data <= mdu_C;
      res_ov <= mdu_D[0];
      cr_lt <= mdu_C[0];
      cr_gt <= !mdu_C[0] && |mdu_C;
      cr_eq <= mdu_C == '0;
      if (oe_q && mdu_D[0]) so <= 1'b1;
    end else if (state == EXEC) begin
      cnt <= cnt - 6'd1;
    end
  end
  always_comb begin
    busy = state != IDLE;
    res_valid = state == DONE;
    mdu_A = busy ? a_q : '0;
    mdu_B = busy ? b_q : '0;
    mdu_Op = busy ? op_q : '0;
    res_so = so;
    res_cr0 = {cr_lt, cr_gt, cr_eq, so};
    res_xer_we = oe_q && res_valid;
    res_cr0_we = rc_q && res_valid;
  end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed self-checking bench for mdu_seq with the MDU result driven by hand.
module tb_mdu_seq;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, start = 1'b0, oe = 1'b0, rc = 1'b0, res_ready = 1'b0;
  logic [0:3] op = '0, mdu_Op, mdu_D = '0, res_cr0;
  logic [0:31] srcA = '0, srcB = '0, mdu_A, mdu_B, mdu_C = '0, res_data;
  logic busy, res_valid, res_ov, res_so, res_xer_we, res_cr0_we;
  int checks = 0, errors = 0, n;
  mdu_seq dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .oe(oe), .rc(rc), .busy(busy), .mdu_A(mdu_A), .mdu_B(mdu_B), .mdu_Op(mdu_Op), .mdu_C(mdu_C),
    .mdu_D(mdu_D), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ov(res_ov),
    .res_so(res_so), .res_cr0(res_cr0), .res_xer_we(res_xer_we), .res_cr0_we(res_cr0_we)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [0:3] o, input logic [0:31] a, input logic [0:31] b, input logic e, input logic r);
    op = o; srcA = a; srcB = b; oe = e; rc = r; start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!res_valid && cnt < 200) begin
      step();
      cnt++;
    end
  endtask
  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_cr0", res_cr0, 0);
    chk("rst_op", mdu_Op, 0);
    chk("rst_we", {res_xer_we, res_cr0_we, res_so, res_ov}, 0);
    step();
    rst_n = 1'b1;
    step();
    issue(4'd7, 32'd1, 32'd1, 1'b0, 1'b0);
    chk("bad_op_ignored", busy, 0);
    mdu_C = 32'hFFFF_FFFD; mdu_D = 4'b0000; res_ready = 1'b1;
    issue(4'd3, 32'd3, 32'hFFFF_FFFF, 1'b1, 1'b1);
    chk("mulw_busy", busy, 1);
    chk("mulw_ops", {mdu_Op, mdu_A, mdu_B}, {4'd3, 32'd3, 32'hFFFF_FFFF});
    wait_valid(n);
    chk("mulw_lat", n, 4);
    chk("mulw_data", res_data, 32'hFFFF_FFFD);
    chk("mulw_ov_so", {res_ov, res_so}, 2'b00);
    chk("mulw_cr0", res_cr0, 4'b1000);
    chk("mulw_we", {res_xer_we, res_cr0_we}, 2'b11);
    step();
    chk("mulw_idle", {busy, res_valid, mdu_Op}, 0);
    mdu_C = 32'd14; res_ready = 1'b0;
    issue(4'd5, 32'd100, 32'd7, 1'b0, 1'b0);
    wait_valid(n);
    chk("divwu_lat", n, 34);
    chk("divwu_cr0_we", {res_xer_we, res_cr0_we, res_cr0}, {2'b00, 4'b0100});
    op = 4'd3; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("divwu_hold", {busy, res_valid, res_data, mdu_Op}, {2'b11, 32'd14, 4'd5});
    end
    res_ready = 1'b1;
    step();
    start = 1'b0;
    chk("handshake_start_ignored", {busy, res_valid}, 2'b00);
    mdu_C = 32'd5; mdu_D = 4'b1000;
    issue(4'd3, 32'd1, 32'd5, 1'b1, 1'b0);
    wait_valid(n);
    chk("ov_lat", n, 4);
    chk("ov_flags", {res_ov, res_so, res_cr0}, {2'b11, 4'b0101});
    step();
    mdu_C = 32'd0; mdu_D = 4'b0000;
    issue(4'd2, 32'd0, 32'd0, 1'b0, 1'b1);
    wait_valid(n);
    chk("mulhu_flags", {res_ov, res_so, res_cr0}, {2'b01, 4'b0011});
    step();
    issue(4'd4, 32'd9, 32'd3, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("flush_pre_valid", res_valid, 0);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_idle", {busy, res_valid}, 2'b00);
    chk("flush_so_kept", res_so, 1);
    mdu_C = 32'h7;
    issue(4'd1, 32'd2, 32'd2, 1'b0, 1'b0);
    chk("post_flush_accept", {busy, mdu_Op}, {1'b1, 4'd1});
    wait_valid(n);
    chk("post_flush_lat", n, 4);
    chk("post_flush_data", res_data, 32'h7);
    step();
    issue(4'd3, 32'd1, 32'd1, 1'b1, 1'b1);
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst", {busy, res_valid, mdu_Op, mdu_A, res_so, res_cr0, res_data}, 0);
    step();
    rst_n = 1'b1;
    step();
    mdu_C = 32'h1234; mdu_D = 4'b1000;
    issue(4'd4, 32'd50, 32'd0, 1'b1, 1'b0);
    wait_valid(n);
`ifdef MDU_DIV0_EARLY_EN
    chk("div0_lat", n, 0);
    chk("div0_data", res_data, 0);
`else
    chk("div0_lat", n, 34);
    chk("div0_data", res_data, 32'h1234);
`endif
    chk("div0_ov_so", {res_ov, res_so}, 2'b11);
    step();
    chk("div0_done", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
